// File: rtl/koala_absorb.sv
// Sponge absorb front-end for the Koala permutation: XOR message words into a 257-bit state.
// Define KOALA_ABSORB_PERM_REG_EN to register the permutation result (2-cycle PERM).
module koala_absorb #(
  parameter int RATE_WORDS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [256:0] perm_i,
  input  logic [256:0] perm_o,
  output logic [256:0] out_state,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int WCW = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
  localparam logic [WCW-1:0] LAST_WC = WCW'(RATE_WORDS - 1);

  typedef enum logic [1:0] {
    ABSORB,
    PAD,
    PERM,
    DONE
  } state_t;

  state_t         r_state;
  logic [256:0]   r_s;
  logic [WCW-1:0] r_wc;
  logic           r_fin;
  logic           r_pend;

`ifdef KOALA_ABSORB_PERM_REG_EN
  logic [256:0]   r_p;
  logic           r_ph;
`endif

  logic [256:0]   w_absorb;
  logic           w_accept;
  logic           w_wc_last;
  state_t         w_perm_nxt;

  assign perm_i    = r_s;
  assign in_ready  = rst_n & (r_state == ABSORB);
  assign out_valid = (r_state == DONE);
  assign out_state = out_valid ? r_s : '0;

  assign w_accept  = in_valid & in_ready;
  assign w_wc_last = (r_wc == LAST_WC);

  always_comb begin
    w_perm_nxt = ABSORB;
    if (r_fin)
      w_perm_nxt = DONE;
    else if (r_pend)
      w_perm_nxt = PAD;
  end

  // A short final block carries its own pad bit right after the last word.
  always_comb begin
    w_absorb = r_s;
    for (int k = 0; k < RATE_WORDS; k++) begin
      if (r_wc == WCW'(k)) begin
        w_absorb[32*k +: 32] = r_s[32*k +: 32] ^ in_data;
        if (in_last && (k < RATE_WORDS - 1)) begin
          w_absorb[32*(k+1)] = ~r_s[32*(k+1)];
          w_absorb[256]      = ~r_s[256];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ABSORB;
      r_s     <= '0;
      r_wc    <= '0;
      r_fin   <= 1'b0;
      r_pend  <= 1'b0;
`ifdef KOALA_ABSORB_PERM_REG_EN
      r_p     <= '0;
      r_ph    <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        ABSORB: begin
          if (w_accept) begin
            r_s <= w_absorb;
            if (in_last || w_wc_last) begin
              r_wc    <= '0;
              r_fin   <= in_last & ~w_wc_last;
              r_pend  <= in_last & w_wc_last;
              r_state <= PERM;
            end else begin
              r_wc <= r_wc + WCW'(1);
            end
          end
        end
        PAD: begin
          r_s[0]   <= ~r_s[0];
          r_s[256] <= ~r_s[256];
          r_fin    <= 1'b1;
          r_pend   <= 1'b0;
          r_state  <= PERM;
        end
        PERM: begin
`ifdef KOALA_ABSORB_PERM_REG_EN
          if (!r_ph) begin
            r_p  <= perm_o;
            r_ph <= 1'b1;
          end else begin
            r_ph    <= 1'b0;
            r_s     <= r_p;
            r_state <= w_perm_nxt;
          end
`else
          r_s     <= perm_o;
          r_state <= w_perm_nxt;
`endif
        end
        DONE: begin
          if (out_ready) begin
            r_s     <= '0;
            r_fin   <= 1'b0;
            r_state <= ABSORB;
          end
        end
        default: r_state <= ABSORB;
      endcase
    end
  end

endmodule
